mem_access_unit: RTL and testbench

- Data-memory port controller for the down-sampling processor.
- Takes an 18-bit address and data from the bus-loaded address and data registers.
- Performs one read or write to the 8-bit-wide synchronous pixel RAM.
- On reads, returns the pixel zero-extended to 18 bits for driving back onto the bus. This is the memory-side counterpart of the bus-loaded register path.

---
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus-side and RAM-side signal bundle for mem_access_unit.
// The slave modport is the unit's view; the master modport is the view of whatever drives it.
interface mem_access_unit_if #(
  parameter int ADDR_W = 18,
  parameter int BUS_W  = 18,
  parameter int MEM_W  = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic              busy;
  logic              done;
  logic [BUS_W-1:0]  rdata;
  logic              err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output busy, done, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  busy, done, rdata, err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-access controller between the processor bus registers and the 8-bit pixel RAM.
// Define MEM_ACCESS_RANGE_CHK_EN to reject addresses >= MEM_DEPTH with a one-cycle err pulse.
module mem_access_unit #(
  parameter int ADDR_W    = 18,
  parameter int BUS_W     = 18,
  parameter int MEM_W     = 8,
  parameter int RD_LAT    = 2,
  parameter int MEM_DEPTH = 262144
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [2:0]        LAT_M1  = 3'(RD_LAT - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              oor_q, oor_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [MEM_W-1:0]  rdata_q, rdata_d;
  logic              addr_oor;

`ifdef MEM_ACCESS_RANGE_CHK_EN
  assign addr_oor = ({1'b0, bus.addr} >= DEPTH_C);
`else
  assign addr_oor = 1'b0;
  logic unused_depth;
  assign unused_depth = ^DEPTH_C;
`endif

  // Upper write-data bits never reach the RAM.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[BUS_W-1:MEM_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    oor_d       = oor_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          mem_addr_d  = bus.addr;
          mem_wdata_d = bus.wdata[MEM_W-1:0];
          oor_d       = addr_oor;
          mem_en_d    = !addr_oor;
          mem_we_d    = bus.we && !addr_oor;
          busy_d      = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (oor_q) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (mem_we_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (LAT_M1 == 3'd0) begin
          rdata_d = bus.mem_rdata;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // cnt_q counts the edges still to go, this one included.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rdata_d = bus.mem_rdata;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        oor_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Everything moves on the falling edge, in step with the register file.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      oor_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      oor_q       <= oor_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = {{(BUS_W - MEM_W){1'b0}}, rdata_q};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: two instances (read latency 2 and 1) share one stimulus stream.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_RANGE_CHK_EN
  localparam int DEPTH = 65536;
`else
  localparam int DEPTH = 262144;
`endif

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [17:0] wdata;
    logic        ovl;
    logic [7:0]  exp_mwd;
    logic [17:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [17:0] addr;
  logic [17:0] wdata;
  logic [7:0]  rd2, rd1;
  logic [7:0]  ram2 [65536];
  logic [7:0]  ram1 [65536];
  logic [7:0]  pipe2 [2];
  logic [7:0]  pipe1;
  logic [17:0] prev_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(18), .BUS_W(18), .MEM_W(8)) bus2 ();
  mem_access_unit_if #(.ADDR_W(18), .BUS_W(18), .MEM_W(8)) bus1 ();

  assign bus2.req = req;   assign bus1.req = req;
  assign bus2.we = we;     assign bus1.we = we;
  assign bus2.addr = addr; assign bus1.addr = addr;
  assign bus2.wdata = wdata;
  assign bus1.wdata = wdata;
  assign bus2.mem_rdata = rd2;
  assign bus1.mem_rdata = rd1;

  mem_access_unit #(.RD_LAT(2), .MEM_DEPTH(DEPTH)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_access_unit #(.RD_LAT(1), .MEM_DEPTH(DEPTH)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // RAM models: read data is valid exactly RD_LAT falling edges after the enable edge.
  always @(posedge clk) begin
    if (bus2.mem_en && bus2.mem_we) ram2[bus2.mem_addr[15:0]] = bus2.mem_wdata;
    pipe2[1] = pipe2[0];
    pipe2[0] = (bus2.mem_en && !bus2.mem_we) ? ram2[bus2.mem_addr[15:0]] : 8'hEE;
    rd2 = pipe2[1];
    if (bus1.mem_en && bus1.mem_we) ram1[bus1.mem_addr[15:0]] = bus1.mem_wdata;
    pipe1 = (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr[15:0]] : 8'hEE;
    rd1 = pipe1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(negedge clk);
    #1;
  endtask

  // Checks one instance at edge i after acceptance; done lands at edge d.
  task automatic chk_edge(input string tag, input int lat, input int i, input vec_t v,
                          input logic busy_a, input logic done_a, input logic en_a,
                          input logic err_a, input logic [17:0] rdata_a,
                          input logic [17:0] maddr_a);
    int d;
    d = v.we ? 1 : lat;
    chk({tag, " done"}, 32'(done_a), 32'(i == d));
    chk({tag, " busy"}, 32'(busy_a), 32'(i <= d));
    chk({tag, " mem_en"}, 32'(en_a), 32'd0);
    chk({tag, " err"}, 32'(err_a), 32'd0);
    chk({tag, " mem_addr"}, 32'(maddr_a), 32'(v.addr));
    chk({tag, " rdata"}, 32'(rdata_a), (i >= d) ? 32'(v.exp_rdata) : 32'(prev_rdata));
  endtask

  task automatic run_vec(input int n, input vec_t v);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    edge_wait();
    chk("e0 mem_en2", 32'(bus2.mem_en), 32'd1);
    chk("e0 mem_we2", 32'(bus2.mem_we), 32'(v.we));
    chk("e0 mem_addr2", 32'(bus2.mem_addr), 32'(v.addr));
    chk("e0 mem_wdata2", 32'(bus2.mem_wdata), 32'(v.exp_mwd));
    chk("e0 busy2", 32'(bus2.busy), 32'd1);
    chk("e0 done2", 32'(bus2.done), 32'd0);
    chk("e0 mem_en1", 32'(bus1.mem_en), 32'd1);
    chk("e0 mem_wdata1", 32'(bus1.mem_wdata), 32'(v.exp_mwd));
    if (v.ovl) begin
      req = 1'b1; we = 1'b1; addr = 18'h00030; wdata = 18'h3FF11;
    end else begin
      req = 1'b0;
    end
    for (int i = 1; i <= 4; i++) begin
      if (i == 3) req = 1'b0;
      edge_wait();
      chk_edge("lat2", 2, i, v, bus2.busy, bus2.done, bus2.mem_en, bus2.err,
               bus2.rdata, bus2.mem_addr);
      chk_edge("lat1", 1, i, v, bus1.busy, bus1.done, bus1.mem_en, bus1.err,
               bus1.rdata, bus1.mem_addr);
    end
    $display("VEC %0d we=%0d addr=%05h ovl=%0d rdata2=%05h rdata1=%05h", n, v.we, v.addr,
             v.ovl, bus2.rdata, bus1.rdata);
    prev_rdata = v.exp_rdata;
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 18'h00010, 18'h3FFA5, 1'b0, 8'hA5, 18'h00000};
    vecs[1] = '{1'b0, 18'h00010, 18'h00000, 1'b0, 8'h00, 18'h000A5};
    vecs[2] = '{1'b0, 18'h00020, 18'h3FFFF, 1'b0, 8'hFF, 18'h0005C};
    vecs[3] = '{1'b1, 18'h0FFFF, 18'h00100, 1'b0, 8'h00, 18'h0005C};
    vecs[4] = '{1'b0, 18'h0FFFF, 18'h00000, 1'b0, 8'h00, 18'h00000};
    vecs[5] = '{1'b1, 18'h00020, 18'h000FF, 1'b0, 8'hFF, 18'h00000};
    vecs[6] = '{1'b0, 18'h00020, 18'h12345, 1'b0, 8'h45, 18'h000FF};
    vecs[7] = '{1'b0, 18'h00020, 18'h00000, 1'b1, 8'h00, 18'h000FF};
    vecs[8] = '{1'b1, 18'h00030, 18'h2BC77, 1'b0, 8'h77, 18'h000FF};
    vecs[9] = '{1'b0, 18'h00030, 18'h00000, 1'b0, 8'h00, 18'h00077};

    for (int a = 0; a < 65536; a++) begin
      ram2[a] = 8'h00;
      ram1[a] = 8'h00;
    end
    ram2[16'h0020] = 8'h5C;
    ram1[16'h0020] = 8'h5C;
    pipe2[0] = 8'hEE; pipe2[1] = 8'hEE; pipe1 = 8'hEE;
    rd2 = 8'hEE; rd1 = 8'hEE;

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    edge_wait();
    edge_wait();
    chk("rst busy", 32'(bus2.busy | bus1.busy), 32'd0);
    chk("rst done", 32'(bus2.done | bus1.done), 32'd0);
    chk("rst mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    chk("rst mem_we", 32'(bus2.mem_we), 32'd0);
    chk("rst err", 32'(bus2.err), 32'd0);
    chk("rst rdata", 32'(bus2.rdata), 32'd0);
    chk("rst mem_addr", 32'(bus2.mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(bus2.mem_wdata), 32'd0);
    req = 1'b1; addr = 18'h00020;
    edge_wait();
    chk("rst req mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    chk("rst req busy", 32'(bus2.busy | bus1.busy), 32'd0);
    rst = 1'b0; req = 1'b0;
    edge_wait();
    chk("post rst busy", 32'(bus2.busy | bus1.busy), 32'd0);
    chk("post rst mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    $display("RESET done busy=%0d rdata=%05h", bus2.busy, bus2.rdata);
    prev_rdata = 18'h00000;

    for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

`ifdef MEM_ACCESS_RANGE_CHK_EN
    req = 1'b1; we = 1'b0; addr = 18'h10000; wdata = 18'h00000;
    edge_wait();
    chk("oor e0 mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    chk("oor e0 busy", 32'(bus2.busy & bus1.busy), 32'd1);
    chk("oor e0 err", 32'(bus2.err | bus1.err), 32'd0);
    req = 1'b0;
    edge_wait();
    chk("oor e1 done2", 32'(bus2.done), 32'd1);
    chk("oor e1 err2", 32'(bus2.err), 32'd1);
    chk("oor e1 done1", 32'(bus1.done), 32'd1);
    chk("oor e1 err1", 32'(bus1.err), 32'd1);
    chk("oor e1 mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    chk("oor e1 rdata2", 32'(bus2.rdata), 32'(prev_rdata));
    chk("oor e1 rdata1", 32'(bus1.rdata), 32'(prev_rdata));
    edge_wait();
    chk("oor e2 done", 32'(bus2.done | bus1.done), 32'd0);
    chk("oor e2 err", 32'(bus2.err | bus1.err), 32'd0);
    chk("oor e2 busy", 32'(bus2.busy | bus1.busy), 32'd0);
    $display("RANGE addr=10000 err pulse seen rdata=%05h", bus2.rdata);
    run_vec(10, '{1'b0, 18'h0FFFF, 18'h00000, 1'b0, 8'h00, 18'h00000});
`endif

    // Reset lands on e1 of a read: the access is dropped and rdata cleared.
    req = 1'b1; we = 1'b0; addr = 18'h00030; wdata = 18'h00000;
    edge_wait();
    chk("midrst e0 busy", 32'(bus2.busy & bus1.busy), 32'd1);
    req = 1'b0; rst = 1'b1;
    edge_wait();
    chk("midrst busy", 32'(bus2.busy | bus1.busy), 32'd0);
    chk("midrst done", 32'(bus2.done | bus1.done), 32'd0);
    chk("midrst rdata2", 32'(bus2.rdata), 32'd0);
    chk("midrst rdata1", 32'(bus1.rdata), 32'd0);
    chk("midrst mem_en", 32'(bus2.mem_en | bus1.mem_en), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      chk("midrst after done", 32'(bus2.done | bus1.done), 32'd0);
      chk("midrst after busy", 32'(bus2.busy | bus1.busy), 32'd0);
      chk("midrst after rdata", 32'(bus2.rdata | bus1.rdata), 32'd0);
    end
    $display("MIDRESET read aborted rdata=%05h", bus2.rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
